// File: rtl/ps2_scancode_receiver_pkg.sv
// Shared definitions for the PS/2 scan-code receiver:
// FSM encoding, prefix bytes, error codes and a parity helper.
package ps2_scancode_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    typedef logic [1:0] err_code_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam err_code_t ERR_NONE    = 2'b00;
    localparam err_code_t ERR_PARITY  = 2'b01;
    localparam err_code_t ERR_STOP    = 2'b10;
    localparam err_code_t ERR_TIMEOUT = 2'b11;

    // PS/2 uses odd parity over the 8 data bits plus the parity bit.
    function automatic logic parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_scancode_receiver_if.sv
// Scan-code delivery bundle from the receiver to the keyboard logic.
// master drives the bundle, slave observes it.
interface ps2_scancode_receiver_if;
    import ps2_scancode_receiver_pkg::*;

    logic [7:0] oScanCode;
    logic       oValid;
    logic       oBreak;
    logic       oExtended;
    logic       oError;
    err_code_t  oErrCode;

    modport master (
        output oScanCode, oValid, oBreak, oExtended, oError, oErrCode
    );

    modport slave (
        input oScanCode, oValid, oBreak, oExtended, oError, oErrCode
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a FILTER_LEN-sample glitch filter.
// The filtered level only moves when the whole window agrees.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o
);

    logic                  meta_q;
    logic [FILTER_LEN-1:0] samp_q, samp_d;
    logic                  level_q, level_d;

    // Shift the second synchroniser stage into the window; hold the
    // level unless every sample in the window agrees.
    always_comb begin
        samp_d  = (samp_q << 1) | FILTER_LEN'(meta_q);
        level_d = level_q;
        if (&samp_q) begin
            level_d = 1'b1;
        end else if (~|samp_q) begin
            level_d = 1'b0;
        end
    end

    // Registers reset to the idle-high bus level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= 1'b1;
            samp_q  <= '1;
            level_q <= 1'b1;
        end else begin
            meta_q  <= line_i;
            samp_q  <= samp_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard frame receiver: filters the raw lines, deserialises
// frames, checks parity/stop, watches for stalls and folds F0/E0 prefixes.
module ps2_scancode_receiver
    import ps2_scancode_receiver_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TIMEOUT_W      = 16
) (
    input  logic Clock,
    input  logic Reset,
    input  logic iPS2Clk,
    input  logic iPS2Data,
    ps2_scancode_receiver_if.master bus
);

    localparam logic [TIMEOUT_W-1:0] WDOG_LAST =
        TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic clk_f;
    logic data_f;
    logic clk_prev_q;
    logic fall;
    logic timeout;

    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;
    logic                   pbrk_q, pbrk_d;
    logic                   pext_q, pext_d;
    logic [7:0]             scan_q, scan_d;
    logic                   valid_q, valid_d;
    logic                   brk_q, brk_d;
    logic                   ext_q, ext_d;
    logic                   err_q, err_d;
    err_code_t              code_q, code_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i   (Clock),
        .rst_ni  (Reset),
        .line_i  (iPS2Clk),
        .level_o (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_i   (Clock),
        .rst_ni  (Reset),
        .line_i  (iPS2Data),
        .level_o (data_f)
    );

    // A falling filtered clock is the only moment data is sampled;
    // an edge in the expiry cycle cancels the timeout.
    assign fall    = clk_prev_q & ~clk_f;
    assign timeout = (state_q != ST_IDLE) && !fall && (wdog_q == WDOG_LAST);

    // State register and all held outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clk_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            wdog_q     <= '0;
            pbrk_q     <= 1'b0;
            pext_q     <= 1'b0;
            scan_q     <= '0;
            valid_q    <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
        end else begin
            clk_prev_q <= clk_f;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            wdog_q     <= wdog_d;
            pbrk_q     <= pbrk_d;
            pext_q     <= pext_d;
            scan_q     <= scan_d;
            valid_q    <= valid_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    // Next-state: frame sequencing, bit shifting and the watchdog.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        wdog_d  = (state_q == ST_IDLE || fall) ? '0 : wdog_q + 1'b1;
        if (timeout) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!data_f) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end
                ST_DATA: begin
                    shreg_d = {data_f, shreg_q[7:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = data_f;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs: evaluate the frame at the stop edge, fold prefixes,
    // and report errors; any error drops the pending prefixes.
    always_comb begin
        scan_d  = scan_q;
        brk_d   = brk_q;
        ext_d   = ext_q;
        code_d  = code_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        pbrk_d  = pbrk_q;
        pext_d  = pext_q;
        if (fall && state_q == ST_STOP) begin
            if (!data_f) begin
                err_d  = 1'b1;
                code_d = ERR_STOP;
                pbrk_d = 1'b0;
                pext_d = 1'b0;
            end else if (!parity_ok(shreg_q, par_q)) begin
                err_d  = 1'b1;
                code_d = ERR_PARITY;
                pbrk_d = 1'b0;
                pext_d = 1'b0;
            end else if (shreg_q == PS2_BREAK) begin
                pbrk_d = 1'b1;
            end else if (shreg_q == PS2_EXT) begin
                pext_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                scan_d  = shreg_q;
                brk_d   = pbrk_q;
                ext_d   = pext_q;
                pbrk_d  = 1'b0;
                pext_d  = 1'b0;
            end
        end else if (timeout) begin
            err_d  = 1'b1;
            code_d = ERR_TIMEOUT;
            pbrk_d = 1'b0;
            pext_d = 1'b0;
        end
    end

    assign bus.oScanCode = scan_q;
    assign bus.oValid    = valid_q;
    assign bus.oBreak    = brk_q;
    assign bus.oExtended = ext_q;
    assign bus.oError    = err_q;
    assign bus.oErrCode  = code_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver: frame table plus
// hand-written timeout, glitch and mid-frame reset sequences.
module tb_ps2_scancode_receiver;
    import ps2_scancode_receiver_pkg::*;

    localparam int FL = 8;
    localparam int TO = 300;
    localparam int H  = 20;
    localparam int NV = 19;

    typedef struct {
        logic [7:0] b;
        logic       badp;
        logic       stop;
        int         ev;
        logic [7:0] code;
        logic       brk;
        logic       ext;
        int         ee;
        logic [1:0] ecode;
    } vec_t;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic ps2c  = 1'b1;
    logic ps2d  = 1'b1;

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_err   = 0;
    int viol    = 0;
    logic pv = 1'b0;
    logic pe = 1'b0;

    vec_t tbl [NV];

    ps2_scancode_receiver_if bus ();

    ps2_scancode_receiver #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_W      (16)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .iPS2Clk  (ps2c),
        .iPS2Data (ps2d),
        .bus      (bus)
    );

    always #5 Clock = ~Clock;

    // Pulse counter and one-cycle / mutual-exclusion watcher.
    always @(negedge Clock) begin
        if (Reset) begin
            if (bus.oValid) n_valid <= n_valid + 1;
            if (bus.oError) n_err <= n_err + 1;
            if ((bus.oValid && bus.oError) || (bus.oValid && pv) ||
                (bus.oError && pe))
                viol <= viol + 1;
        end
        pv <= bus.oValid;
        pe <= bus.oError;
    end

    function automatic vec_t mkv(input logic [7:0] b, input logic badp,
                                 input logic stop, input int ev,
                                 input logic [7:0] code, input logic brk,
                                 input logic ext, input int ee,
                                 input logic [1:0] ecode);
        vec_t v;
        v.b = b; v.badp = badp; v.stop = stop; v.ev = ev; v.code = code;
        v.brk = brk; v.ext = ext; v.ee = ee; v.ecode = ecode;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic bit_out(input logic v, input bit gl);
        ps2d = v;
        if (gl) begin
            cyc(6);
            ps2c = 1'b0;
            cyc(3);
            ps2c = 1'b1;
            cyc(H - 9);
        end else begin
            cyc(H);
        end
        ps2c = 1'b0;
        cyc(H);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic badp,
                              input logic stop, input bit gl);
        logic p;
        p = ~^b ^ badp;
        bit_out(1'b0, gl);
        for (int i = 0; i < 8; i++) bit_out(b[i], gl);
        bit_out(p, gl);
        bit_out(stop, gl);
        ps2d = 1'b1;
        cyc(30);
    endtask

    task automatic run_vec(input vec_t v, input string nm, input bit gl);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_frame(v.b, v.badp, v.stop, gl);
        chk({nm, ".nvalid"}, n_valid - v0, v.ev);
        chk({nm, ".nerr"}, n_err - e0, v.ee);
        if (v.ev != 0) begin
            chk({nm, ".code"}, int'(bus.oScanCode), int'(v.code));
            chk({nm, ".brk"}, int'(bus.oBreak), int'(v.brk));
            chk({nm, ".ext"}, int'(bus.oExtended), int'(v.ext));
        end
        if (v.ee != 0)
            chk({nm, ".ecode"}, int'(bus.oErrCode), int'(v.ecode));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".code"}, int'(bus.oScanCode), 0);
        chk({nm, ".valid"}, int'(bus.oValid), 0);
        chk({nm, ".brk"}, int'(bus.oBreak), 0);
        chk({nm, ".ext"}, int'(bus.oExtended), 0);
        chk({nm, ".err"}, int'(bus.oError), 0);
        chk({nm, ".ecode"}, int'(bus.oErrCode), 0);
    endtask

    initial begin
        int v0, e0, first;
        logic [7:0] tb;

        tbl[0]  = mkv(8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0, 0, 2'b00);
        tbl[1]  = mkv(8'hF0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 0, 2'b00);
        tbl[2]  = mkv(8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b1, 1'b0, 0, 2'b00);
        tbl[3]  = mkv(8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0, 0, 2'b00);
        tbl[4]  = mkv(8'hE0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 0, 2'b00);
        tbl[5]  = mkv(8'hF0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 0, 2'b00);
        tbl[6]  = mkv(8'h75, 1'b0, 1'b1, 1, 8'h75, 1'b1, 1'b1, 0, 2'b00);
        tbl[7]  = mkv(8'h1C, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0, 1, 2'b01);
        tbl[8]  = mkv(8'hF0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 0, 2'b00);
        tbl[9]  = mkv(8'h1C, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0, 1, 2'b01);
        tbl[10] = mkv(8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0, 0, 2'b00);
        tbl[11] = mkv(8'h5A, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1, 2'b10);
        tbl[12] = mkv(8'hE0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 0, 2'b00);
        tbl[13] = mkv(8'h6B, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1, 2'b10);
        tbl[14] = mkv(8'h6B, 1'b0, 1'b1, 1, 8'h6B, 1'b0, 1'b0, 0, 2'b00);
        tbl[15] = mkv(8'h00, 1'b0, 1'b1, 1, 8'h00, 1'b0, 1'b0, 0, 2'b00);
        tbl[16] = mkv(8'hFF, 1'b0, 1'b1, 1, 8'hFF, 1'b0, 1'b0, 0, 2'b00);
        tbl[17] = mkv(8'hE0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 0, 2'b00);
        tbl[18] = mkv(8'h6B, 1'b0, 1'b1, 1, 8'h6B, 1'b0, 1'b1, 0, 2'b00);

        cyc(4);
        chk_zero("reset");
        Reset = 1'b1;
        cyc(20);
        chk_zero("post_reset");

        for (int i = 0; i < NV; i++)
            run_vec(tbl[i], $sformatf("v%0d", i), 1'b0);

        // Stall after four data bits of 29.
        tb = 8'h29;
        v0 = n_valid;
        e0 = n_err;
        first = -1;
        bit_out(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) bit_out(tb[i], 1'b0);
        ps2d = tb[3];
        cyc(H);
        ps2c = 1'b0;
        for (int k = 1; k <= FL + TO + 20; k++) begin
            @(negedge Clock);
            if (k == H) ps2c = 1'b1;
            if (first < 0 && bus.oError) first = k;
        end
        ps2d = 1'b1;
        cyc(5);
        chk("timeout.lat", first, FL + 3 + TO);
        chk("timeout.ecode", int'(bus.oErrCode), int'(ERR_TIMEOUT));
        chk("timeout.nerr", n_err - e0, 1);
        chk("timeout.nvalid", n_valid - v0, 0);
        run_vec(mkv(8'h29, 1'b0, 1'b1, 1, 8'h29, 1'b0, 1'b0, 0, 2'b00),
                "after_to", 1'b0);

        // Glitchy clock during a 1C frame.
        run_vec(mkv(8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0, 0, 2'b00),
                "glitch", 1'b1);

        // Pending break then reset mid-frame.
        run_vec(mkv(8'hF0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 0, 2'b00),
                "pre_rst", 1'b0);
        tb = 8'h1C;
        v0 = n_valid;
        e0 = n_err;
        bit_out(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) bit_out(tb[i], 1'b0);
        ps2d = tb[4];
        cyc(H);
        ps2c = 1'b0;
        cyc(H / 2);
        Reset = 1'b0;
        ps2c = 1'b1;
        ps2d = 1'b1;
        cyc(2);
        chk_zero("in_reset");
        cyc(5);
        Reset = 1'b1;
        cyc(30);
        chk("rst.nvalid", n_valid - v0, 0);
        chk("rst.nerr", n_err - e0, 0);
        run_vec(mkv(8'h5A, 1'b0, 1'b1, 1, 8'h5A, 1'b0, 1'b0, 0, 2'b00),
                "after_rst", 1'b0);

        chk("pulse_rules", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
